// File: rtl/npc_pkg.sv
// npc_pkg: shared constants and types for the npc core front end.
//   XLEN             datapath width
//   RESET_PC_DEFAULT default fetch PC after reset
//   INST_EBREAK      ebreak encoding, used by the optional fetch halt
//   ifu_state_e      fetch unit run/halt state
//   ifu_entry_t      instruction buffer entry {pc, inst}
package npc_pkg;

    localparam int              XLEN             = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h8000_0000;
    localparam logic [XLEN-1:0] INST_EBREAK      = 32'h0010_0073;

    typedef enum logic {
        IFU_RUN  = 1'b0,
        IFU_HALT = 1'b1
    } ifu_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } ifu_entry_t;

endpackage

// File: rtl/npc_ifu_fifo.sv
// npc_ifu_fifo: synchronous FIFO with flush and occupancy count.
//   DEPTH  entries (any value >= 1)
//   WIDTH  entry width
// Ports:
//   clk_i    clock
//   rst_ni   synchronous reset, active low
//   flush_i  empties the FIFO; a same-cycle push/pop is discarded
//   push_i   write wdata_i (ignored when full unless a pop frees the slot)
//   pop_i    advance the head (ignored when empty)
//   rdata_o  head entry (registered storage, no write-through bypass)
//   count_o  current occupancy
module npc_ifu_fifo #(
    parameter  int DEPTH = 2,
    parameter  int WIDTH = 64,
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wptr_q, rptr_q;
    logic [CW-1:0]    cnt_q;
    logic             full, empty, do_push, do_pop;

    // Explicit wrap so non-power-of-2 depths also work.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (cnt_q == CW'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign do_pop  = pop_i && !empty;
    // At full, a simultaneous pop frees the head slot, which is the slot being written.
    assign do_push = push_i && (!full || do_pop);

    always_ff @(posedge clk_i) begin
        if (!rst_ni || flush_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) wptr_q <= ptr_inc(wptr_q);
            if (do_pop)  rptr_q <= ptr_inc(rptr_q);
            cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage needs no reset: contents are only observed while count_o != 0.
    always_ff @(posedge clk_i) begin
        if (rst_ni && !flush_i && do_push) mem_q[wptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rptr_q];
    assign count_o = cnt_q;

endmodule

// File: rtl/npc_ifu.sv
// npc_ifu: instruction fetch unit. Owns the PC, issues in-order word fetches,
// buffers returned words with their PCs and hands {inst, inst_pc} to decode.
// Redirects from execute flush the buffer and discard responses still owed
// for the abandoned path.
// Optional feature: define NPC_IFU_EBREAK_HALT_EN to stop fetching once an
// ebreak word enters the buffer (halted=1 until redirect or reset).
// Ports:
//   clk, rst (sync, active low)
//   redirect_valid/redirect_pc         PC change from execute
//   imem_req_valid/ready/addr          fetch request bus
//   imem_rsp_valid/data                in-order responses, no backpressure
//   inst_valid/ready, inst, inst_pc    buffer head toward decode
//   halted                             fetch stopped on ebreak
module npc_ifu
    import npc_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int              FIFO_DEPTH = 2,
    parameter int              MAX_OUTST  = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc,
    output logic            halted
);

    localparam int FCW    = $clog2(FIFO_DEPTH + 1);
    localparam int PCW    = $clog2(MAX_OUTST + 1);
    // Owed responses accumulate across back-to-back redirects.
    localparam int DROP_W = 8;

    logic [XLEN-1:0]   pc_q, pc_d;
    logic [DROP_W-1:0] drop_q, drop_d;
    ifu_state_e        state_q;
    logic              halted_q;

    logic [FCW-1:0]    fifo_cnt;
    logic [PCW-1:0]    outst;
    logic [XLEN-1:0]   rsp_pc;
    ifu_entry_t        head, push_entry;
    logic              credit_ok, req_fire, live_rsp, push, hit_ebreak;

    // Every accepted request reserves a buffer slot so a response never blocks.
    assign credit_ok = (32'(outst) < 32'(MAX_OUTST)) &&
                       (32'(outst) + 32'(fifo_cnt) < 32'(FIFO_DEPTH));

    assign imem_req_valid = rst && (state_q == IFU_RUN) && !redirect_valid && credit_ok;
    assign imem_req_addr  = pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // A response is live only when nothing from a flushed path is still owed.
    assign live_rsp = imem_rsp_valid && !redirect_valid && (drop_q == '0);
    // In HALT, live responses retire their PC but the word is discarded.
    assign push     = live_rsp && (state_q == IFU_RUN);

`ifdef NPC_IFU_EBREAK_HALT_EN
    assign hit_ebreak = push && (imem_rsp_data == INST_EBREAK);
`else
    assign hit_ebreak = 1'b0;
`endif

    // PC queue: one entry per live request, so its occupancy is the live
    // outstanding count; a redirect flush hands tracking over to drop_q.
    npc_ifu_fifo #(
        .DEPTH (MAX_OUTST),
        .WIDTH (XLEN)
    ) u_pcq (
        .clk_i   (clk),
        .rst_ni  (rst),
        .flush_i (redirect_valid),
        .push_i  (req_fire),
        .wdata_i (pc_q),
        .pop_i   (live_rsp),
        .rdata_o (rsp_pc),
        .count_o (outst)
    );

    assign push_entry = '{pc: rsp_pc, inst: imem_rsp_data};

    npc_ifu_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (2 * XLEN)
    ) u_ibuf (
        .clk_i   (clk),
        .rst_ni  (rst),
        .flush_i (redirect_valid),
        .push_i  (push),
        .wdata_i (push_entry),
        .pop_i   (inst_valid && inst_ready),
        .rdata_o (head),
        .count_o (fifo_cnt)
    );

    assign inst_valid = (fifo_cnt != '0);
    assign inst       = inst_valid ? head.inst : '0;
    assign inst_pc    = inst_valid ? head.pc   : '0;
    assign halted     = halted_q;

    always_comb begin
        pc_d   = pc_q;
        drop_d = drop_q;
        if (redirect_valid) begin
            pc_d   = redirect_pc & 32'hFFFF_FFFC;
            // Live requests become owed; a response landing now is already gone.
            drop_d = drop_q + DROP_W'(outst) - DROP_W'(imem_rsp_valid);
        end else begin
            if (req_fire)                         pc_d   = pc_q + 32'd4;
            if (imem_rsp_valid && drop_q != '0)   drop_d = drop_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_q   <= RESET_PC;
            drop_q <= '0;
        end else begin
            pc_q   <= pc_d;
            drop_q <= drop_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IFU_RUN;
            halted_q <= 1'b0;
        end else begin
            case (state_q)
                IFU_RUN: begin
                    if (hit_ebreak) begin
                        state_q  <= IFU_HALT;
                        halted_q <= 1'b1;
                    end
                end
                IFU_HALT: begin
                    if (redirect_valid) begin
                        state_q  <= IFU_RUN;
                        halted_q <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= IFU_RUN;
                    halted_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_npc_ifu.sv
module tb_npc_ifu;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        halted;

    always #5 clk = ~clk;

    npc_ifu dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .halted         (halted)
    );

    localparam logic [31:0] RST_PC = 32'h8000_0000;

    int          vectors = 0;
    int          errs    = 0;
    int          n_pop   = 0;
    int          n_acc   = 0;
    bit          auto_mem;
    bit          ebrk_inj;
    bit          found;
    logic [31:0] exp_pc, exp_req;
    logic [31:0] pq[$];

    function automatic logic [31:0] memword(input logic [31:0] a);
        if (ebrk_inj && a == 32'h8000_0008) return 32'h0010_0073;
        return a ^ 32'h1357_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // One clock: check the handshakes of the current cycle, cross the edge,
    // then present the in-order 1-cycle memory response (when enabled).
    task automatic tick();
        logic        acc;
        logic [31:0] a;
        #2;
        acc = imem_req_valid && imem_req_ready;
        a   = imem_req_addr;
        if (!rst) begin
            pq.delete();
            exp_pc  = RST_PC;
            exp_req = RST_PC;
        end else if (redirect_valid) begin
            chk("req_during_redirect", 32'(acc), 32'd0);
            exp_pc  = redirect_pc & 32'hFFFF_FFFC;
            exp_req = redirect_pc & 32'hFFFF_FFFC;
        end else begin
            if (inst_valid && inst_ready) begin
                chk("inst_pc", inst_pc, exp_pc);
                chk("inst", inst, memword(exp_pc));
                exp_pc = exp_pc + 32'd4;
                n_pop++;
            end
            if (acc) begin
                chk("req_addr", a, exp_req);
                exp_req = exp_req + 32'd4;
                n_acc++;
            end
        end
        if (rst && acc) pq.push_back(a);
        @(posedge clk);
        #1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        if (rst && auto_mem && pq.size() > 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = memword(pq.pop_front());
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk_reset_outputs();
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_inst_valid", 32'(inst_valid), 32'd0);
        chk("rst_inst", inst, 32'd0);
        chk("rst_inst_pc", inst_pc, 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
    endtask

    initial begin
        rst = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        inst_ready = 1'b1; auto_mem = 1'b1; ebrk_inj = 1'b0;
        exp_pc = RST_PC; exp_req = RST_PC;

        // Reset state
        run(2);
        #2;
        chk_reset_outputs();

        // 1: sequential fetch, 1-cycle memory, decode always ready
        rst = 1'b1;
        #2;
        chk("first_req_valid", 32'(imem_req_valid), 32'd1);
        chk("first_req_addr", imem_req_addr, RST_PC);
        run(20);
        chk("stream_progress", 32'(n_pop >= 10), 32'd1);

        // 2: decode stalls; buffer fills to FIFO_DEPTH and requests stop
        inst_ready = 1'b0;
        run(10);
        #2;
        chk("stall_req_valid", 32'(imem_req_valid), 32'd0);
        chk("stall_inst_valid", 32'(inst_valid), 32'd1);
        chk("stall_buffered", 32'(n_acc - n_pop), 32'd2);
        inst_ready = 1'b1;
        run(10);

        // 4: redirect in a cycle with a response and a pop
        found = 1'b0;
        for (int i = 0; i < 12; i++) begin
            #2;
            if (inst_valid && imem_rsp_valid) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        chk("redir_overlap_found", 32'(found), 32'd1);
        redirect_valid = 1'b1; redirect_pc = 32'h8000_0203;
        tick();
        redirect_valid = 1'b0;
        #2;
        chk("redir_flush_empty", 32'(inst_valid), 32'd0);
        chk("redir_req_addr", imem_req_addr, 32'h8000_0200);
        run(15);

        // 3: two requests outstanding, redirect to a misaligned target
        auto_mem = 1'b0;
        run(6);
        #2;
        chk("outst_req_blocked", 32'(imem_req_valid), 32'd0);
        chk("outst_pending", 32'(pq.size()), 32'd2);
        redirect_valid = 1'b1; redirect_pc = 32'h8000_0101;
        tick();
        redirect_valid = 1'b0;
        #2;
        chk("redir2_req_valid", 32'(imem_req_valid), 32'd1);
        chk("redir2_req_addr", imem_req_addr, 32'h8000_0100);
        auto_mem = 1'b1;
        n_pop = 0;
        run(15);
        chk("redir2_progress", 32'(n_pop >= 6), 32'd1);

        // 6: reset mid-stream with requests pending
        rst = 1'b0;
        tick();
        #2;
        chk_reset_outputs();
        rst = 1'b1;
        #2;
        chk("rerst_req_valid", 32'(imem_req_valid), 32'd1);
        chk("rerst_req_addr", imem_req_addr, RST_PC);
        run(8);

        // 5: ebreak at 0x80000008
        rst = 1'b0;
        tick();
        rst = 1'b1; ebrk_inj = 1'b1;
        run(12);
        #2;
`ifdef NPC_IFU_EBREAK_HALT_EN
        chk("ebrk_halted", 32'(halted), 32'd1);
        chk("ebrk_req_stopped", 32'(imem_req_valid), 32'd0);
        chk("ebrk_no_more_inst", 32'(inst_valid), 32'd0);
        chk("ebrk_last_pc", exp_pc, 32'h8000_000C);
`else
        chk("ebrk_not_halted", 32'(halted), 32'd0);
        chk("ebrk_fetch_continues", 32'(exp_pc > 32'h8000_000C), 32'd1);
`endif
        ebrk_inj = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'h8000_0000;
        tick();
        redirect_valid = 1'b0;
        #2;
        chk("resume_halted", 32'(halted), 32'd0);
        chk("resume_req_valid", 32'(imem_req_valid), 32'd1);
        chk("resume_req_addr", imem_req_addr, 32'h8000_0000);
        run(10);
        chk("resume_progress", 32'(exp_pc >= 32'h8000_0010), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
